// File: rtl/sal_sched_pkg.sv
// Shared definitions for the DRAM command scheduler: command encoding,
// arbitration class indices and the timing-counter width.
package sal_sched_pkg;

    localparam int TW = 5;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_e;

    // Arbitration classes; a lower index means a higher priority.
    localparam logic [1:0] CLS_REF = 2'd0;
    localparam logic [1:0] CLS_PRE = 2'd1;
    localparam logic [1:0] CLS_COL = 2'd2;
    localparam logic [1:0] CLS_ACT = 2'd3;
    localparam int         NUM_CLS = 4;

    // Countdown step that stops at zero.
    function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

endpackage

// File: rtl/sal_rr_arb.sv
// Round-robin arbiter: the search starts at bank ptr and wraps around.
// Produces a one-hot grant and its index. NUM_BK must be a power of 2.
module sal_rr_arb #(
    parameter int NUM_BK = 4
) (
    input  logic [NUM_BK-1:0]         req,
    input  logic [$clog2(NUM_BK)-1:0] ptr,
    output logic [NUM_BK-1:0]         gnt,
    output logic [$clog2(NUM_BK)-1:0] idx
);

    localparam int IDX_W = $clog2(NUM_BK);

    logic [IDX_W-1:0] cand;
    logic             found;

    // Scan upward from the pointer, wrapping; the first requester wins.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path infers a latch.
        gnt   = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_BK; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/sal_cmd_sched.sv
// Inter-bank command scheduler. Arbitrates per-bank REF/PRE/RD/WR/ACT
// requests (one grant per cycle, combinational), enforces tRRD/tCCD/tWTR/tRTW
// spacing and drives a registered command bus toward the PHY.
// Optional four-activate window: define SAL_SCHED_FAW_EN.
module sal_cmd_sched
    import sal_sched_pkg::*;
#(
    parameter int NUM_BK = 4,
    parameter int RA_W   = 14,
    parameter int CA_W   = 10,
    parameter int META_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_BK-1:0]          act_req_i,
    input  logic [NUM_BK-1:0]          rd_req_i,
    input  logic [NUM_BK-1:0]          wr_req_i,
    input  logic [NUM_BK-1:0]          pre_req_i,
    input  logic [NUM_BK-1:0]          ref_req_i,
    input  logic [NUM_BK*RA_W-1:0]     ra_i,
    input  logic [NUM_BK*CA_W-1:0]     ca_i,
    input  logic [NUM_BK*META_W-1:0]   meta_i,
    output logic [NUM_BK-1:0]          act_gnt_o,
    output logic [NUM_BK-1:0]          rd_gnt_o,
    output logic [NUM_BK-1:0]          wr_gnt_o,
    output logic [NUM_BK-1:0]          pre_gnt_o,
    output logic [NUM_BK-1:0]          ref_gnt_o,
    input  logic [4:0]                 t_rrd_m1_i,
    input  logic [4:0]                 t_ccd_m1_i,
    input  logic [4:0]                 t_wtr_m1_i,
    input  logic [4:0]                 t_rtw_m1_i,
    input  logic [4:0]                 t_faw_m1_i,
    output logic [2:0]                 cmd_o,
    output logic [$clog2(NUM_BK)-1:0]  cmd_ba_o,
    output logic [RA_W-1:0]            cmd_ra_o,
    output logic [CA_W-1:0]            cmd_ca_o,
    output logic [META_W-1:0]          cmd_meta_o
);

    localparam int BA_W = $clog2(NUM_BK);

    logic [TW-1:0]     rrd_cnt, ccd_cnt, wtr_cnt, rtw_cnt;
    logic              act_ok, rd_ok, wr_ok, faw_ok;
    logic [NUM_BK-1:0] rd_rq, wr_rq;
    logic [NUM_BK-1:0] cls_req [NUM_CLS];
    logic [NUM_BK-1:0] cls_gnt [NUM_CLS];
    logic [BA_W-1:0]   cls_idx [NUM_CLS];
    logic [BA_W-1:0]   ptr     [NUM_CLS];
    logic [1:0]        sel_cls;
    logic              any_gnt;
    logic [NUM_BK-1:0] gnt_vec;
    logic [BA_W-1:0]   gnt_idx;
    cmd_e              gnt_cmd;
    logic [RA_W-1:0]   sel_ra;
    logic [CA_W-1:0]   sel_ca;
    logic [META_W-1:0] sel_meta;

    assign rd_ok  = (ccd_cnt == '0) && (wtr_cnt == '0);
    assign wr_ok  = (ccd_cnt == '0) && (rtw_cnt == '0);
    assign act_ok = (rrd_cnt == '0) && faw_ok;

    // Requests are masked by timing eligibility so a blocked class falls
    // through to the next one, and by reset so no grant leaks out.
    assign rd_rq            = {NUM_BK{rst_n & rd_ok}} & rd_req_i;
    assign wr_rq            = {NUM_BK{rst_n & wr_ok}} & wr_req_i;
    assign cls_req[CLS_REF] = {NUM_BK{rst_n}} & ref_req_i;
    assign cls_req[CLS_PRE] = {NUM_BK{rst_n}} & pre_req_i;
    assign cls_req[CLS_COL] = rd_rq | wr_rq;
    assign cls_req[CLS_ACT] = {NUM_BK{rst_n & act_ok}} & act_req_i;

    for (genvar c = 0; c < NUM_CLS; c++) begin : g_arb
        sal_rr_arb #(.NUM_BK(NUM_BK)) u_arb (
            .req (cls_req[c]),
            .ptr (ptr[c]),
            .gnt (cls_gnt[c]),
            .idx (cls_idx[c])
        );
    end

    // Pick the highest-priority class that has an eligible requester.
    always_comb begin
        sel_cls = CLS_ACT;
        any_gnt = 1'b0;
        for (int c = NUM_CLS - 1; c >= 0; c--) begin
            if (|cls_req[c]) begin
                sel_cls = 2'(c);
                any_gnt = 1'b1;
            end
        end
    end

    assign gnt_vec   = any_gnt ? cls_gnt[sel_cls] : '0;
    assign gnt_idx   = cls_idx[sel_cls];
    assign ref_gnt_o = (sel_cls == CLS_REF) ? gnt_vec : '0;
    assign pre_gnt_o = (sel_cls == CLS_PRE) ? gnt_vec : '0;
    // A bank asking for both RD and WR gets the RD when it is eligible.
    assign rd_gnt_o  = (sel_cls == CLS_COL) ? (gnt_vec & rd_rq) : '0;
    assign wr_gnt_o  = (sel_cls == CLS_COL) ? (gnt_vec & wr_rq & ~rd_rq) : '0;
    assign act_gnt_o = (sel_cls == CLS_ACT) ? gnt_vec : '0;

    // Encode the granted command for the counters and the bus.
    always_comb begin
        gnt_cmd = CMD_NOP;
        if (any_gnt) begin
            case (sel_cls)
                CLS_REF: gnt_cmd = CMD_REF;
                CLS_PRE: gnt_cmd = CMD_PRE;
                CLS_COL: gnt_cmd = (|(gnt_vec & rd_rq)) ? CMD_RD : CMD_WR;
                default: gnt_cmd = CMD_ACT;
            endcase
        end
    end

    assign sel_ra   = ra_i[gnt_idx*RA_W +: RA_W];
    assign sel_ca   = ca_i[gnt_idx*CA_W +: CA_W];
    assign sel_meta = meta_i[gnt_idx*META_W +: META_W];

    // Inter-bank spacing counters: load on the issuing grant, else count down.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            rrd_cnt <= '0;
            ccd_cnt <= '0;
            wtr_cnt <= '0;
            rtw_cnt <= '0;
        end else begin
            rrd_cnt <= (gnt_cmd == CMD_ACT) ? t_rrd_m1_i : dec_sat(rrd_cnt);
            ccd_cnt <= (gnt_cmd == CMD_RD || gnt_cmd == CMD_WR) ? t_ccd_m1_i : dec_sat(ccd_cnt);
            rtw_cnt <= (gnt_cmd == CMD_RD) ? t_rtw_m1_i : dec_sat(rtw_cnt);
            wtr_cnt <= (gnt_cmd == CMD_WR) ? t_wtr_m1_i : dec_sat(wtr_cnt);
        end
    end

    // Only the granted class moves its pointer past the winner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CLS; c++) ptr[c] <= '0;
        end else if (any_gnt) begin
            ptr[sel_cls] <= gnt_idx + BA_W'(1);
        end
    end

    // Registered command bus; payload fields hold while idle.
    always_ff @(posedge clk) begin
        // NOTE: the payload is cleared in reset as well, so the PHY never sees stale X fields.
        if (!rst_n) begin
            cmd_o      <= CMD_NOP;
            cmd_ba_o   <= '0;
            cmd_ra_o   <= '0;
            cmd_ca_o   <= '0;
            cmd_meta_o <= '0;
        end else begin
            cmd_o <= gnt_cmd;
            if (gnt_cmd != CMD_NOP) begin
                cmd_ba_o   <= gnt_idx;
                cmd_meta_o <= sel_meta;
                cmd_ra_o   <= (gnt_cmd == CMD_PRE || gnt_cmd == CMD_REF) ? '0 : sel_ra;
                cmd_ca_o   <= (gnt_cmd == CMD_RD || gnt_cmd == CMD_WR) ? sel_ca : '0;
            end
        end
    end

`ifdef SAL_SCHED_FAW_EN
    localparam int FAW_SLOTS = 4;
    localparam int FAW_W     = 6;

    logic [FAW_W-1:0] faw_slot [FAW_SLOTS];
    logic [1:0]       faw_free;

    // Lowest free slot; ACT is allowed while any slot is free.
    always_comb begin
        faw_ok   = 1'b0;
        faw_free = '0;
        for (int s = FAW_SLOTS - 1; s >= 0; s--) begin
            if (faw_slot[s] == '0) begin
                faw_ok   = 1'b1;
                faw_free = 2'(s);
            end
        end
    end

    // Each ACT occupies one slot for t_faw_m1+1 cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < FAW_SLOTS; s++) faw_slot[s] <= '0;
        end else begin
            for (int s = 0; s < FAW_SLOTS; s++) begin
                if (gnt_cmd == CMD_ACT && faw_free == 2'(s))
                    faw_slot[s] <= FAW_W'(t_faw_m1_i);
                else if (faw_slot[s] != '0)
                    faw_slot[s] <= faw_slot[s] - 1'b1;
            end
        end
    end
`else
    logic unused_faw;
    assign faw_ok     = 1'b1;
    assign unused_faw = ^t_faw_m1_i;
`endif

endmodule
